// File: rtl/beta_prefetch_buffer_if.sv
// Instruction-memory and fetch-side bus of the prefetch buffer.
// master: the prefetch buffer itself; slave: memory plus fetch consumer.
interface beta_prefetch_buffer_if #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
);
  logic                    instr_req_o;
  logic [AddressWidth-1:0] instr_addr_o;
  logic                    instr_ready_i;
  logic                    instr_valid_i;
  logic [DataWidth-1:0]    instr_rdata_i;
  logic                    fetch_valid_o;
  logic [DataWidth-1:0]    fetch_instr_o;
  logic [AddressWidth-1:0] fetch_addr_o;
  logic                    fetch_ready_i;

  modport master (
    output instr_req_o, instr_addr_o, fetch_valid_o, fetch_instr_o, fetch_addr_o,
    input  instr_ready_i, instr_valid_i, instr_rdata_i, fetch_ready_i
  );

  modport slave (
    input  instr_req_o, instr_addr_o, fetch_valid_o, fetch_instr_o, fetch_addr_o,
    output instr_ready_i, instr_valid_i, instr_rdata_i, fetch_ready_i
  );
endinterface

// File: rtl/beta_prefetch_buffer.sv
// Sequential instruction prefetcher: issues word fetches ahead of the
// consumer under an outstanding/FIFO credit rule, queues returned words with
// their addresses, and flushes/redirects on a branch strobe.
module beta_prefetch_buffer #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned Depth          = 4,
  parameter int unsigned MaxOutstanding = 2,
  parameter logic [AddressWidth-1:0] BootAddr = 'h0000_0080
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    pf_en_i,
  input  logic                    branch_i,
  input  logic [AddressWidth-1:0] branch_addr_i,
  beta_prefetch_buffer_if.master  bus,
  output logic                    pf_busy_o
);

  localparam int unsigned AW = AddressWidth;
  localparam int unsigned OW = $clog2(MaxOutstanding + 1);
  localparam int unsigned CW = $clog2(Depth + 1);
  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned QW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic [1:0] {
    REQ_IDLE,   // no request carried over from the previous cycle
    REQ_HOLD,   // request shown but not accepted, must stay stable
    REQ_STALE   // held request issued before a branch; its response is dropped
  } req_state_e;

  req_state_e req_state_q, req_state_d;

  logic          run_q;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] hold_addr_q;
  logic [OW-1:0] out_q;
  logic [OW-1:0] disc_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] rd_q, wr_q;
  logic [QW-1:0] aq_rd_q, aq_wr_q;

  logic [DataWidth-1:0] fifo_instr [Depth];
  logic [AW-1:0]        fifo_addr  [Depth];
  logic [AW-1:0]        addr_queue [MaxOutstanding];

  logic          credit, req, hold, stale, acc, fresh_acc, resp, push, pop, disc_nz;
  logic [AW-1:0] req_addr;

  // Request generation, handshake decode and FIFO push/pop qualification.
  always_comb begin
    hold      = (req_state_q != REQ_IDLE);
    stale     = (req_state_q == REQ_STALE);
    credit    = (32'(out_q) < MaxOutstanding) && ((32'(cnt_q) + 32'(out_q)) < Depth);
    req       = run_q & (hold | (pf_en_i & credit));
    req_addr  = hold ? hold_addr_q : ptr_q;
    acc       = req & bus.instr_ready_i;
    fresh_acc = acc & ~stale & ~branch_i;
    disc_nz   = (disc_q != '0);
    resp      = bus.instr_valid_i & (out_q != '0);
    push      = resp & ~branch_i & ~disc_nz;
    pop       = (cnt_q != '0) & bus.fetch_ready_i & ~branch_i;

    bus.instr_req_o   = req;
    bus.instr_addr_o  = req ? req_addr : '0;
    bus.fetch_valid_o = (cnt_q != '0);
    bus.fetch_instr_o = (cnt_q != '0) ? fifo_instr[rd_q] : '0;
    bus.fetch_addr_o  = (cnt_q != '0) ? fifo_addr[rd_q]  : '0;
    pf_busy_o         = (out_q != '0) | disc_nz | req;
  end

  // Request hold state: a shown-but-unaccepted request stays on the bus; a
  // branch while it waits marks it stale.
  always_comb begin
    req_state_d = REQ_IDLE;
    if (req && !bus.instr_ready_i) begin
      req_state_d = (branch_i || stale) ? REQ_STALE : REQ_HOLD;
    end
  end

  // Request state register, held address and post-reset start-up delay.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      req_state_q <= REQ_IDLE;
      hold_addr_q <= '0;
      run_q       <= 1'b0;
    end else begin
      req_state_q <= req_state_d;
      hold_addr_q <= req_addr;
      run_q       <= 1'b1;
    end
  end

  // Fetch pointer: branch target wins, otherwise advance on a live acceptance.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_q <= BootAddr & ~AW'(3);
    end else if (branch_i) begin
      ptr_q <= branch_addr_i & ~AW'(3);
    end else if (fresh_acc) begin
      ptr_q <= ptr_q + AW'(4);
    end
  end

  // Outstanding and discard counters. On a branch every request still in
  // flight, including one accepted this cycle, becomes a discard.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_q  <= '0;
      disc_q <= '0;
    end else begin
      out_q <= out_q + OW'(acc) - OW'(resp);
      if (branch_i) begin
        disc_q <= out_q + OW'(acc) - OW'(resp);
      end else begin
        disc_q <= disc_q + OW'(acc & stale) - OW'(resp & disc_nz);
      end
    end
  end

  // FIFO and address-queue pointers; a branch empties both.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      aq_rd_q <= '0;
      aq_wr_q <= '0;
    end else if (branch_i) begin
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      aq_rd_q <= '0;
      aq_wr_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push) wr_q <= wr_q + 1'b1;
      if (fresh_acc) begin
        aq_wr_q <= (aq_wr_q == QW'(MaxOutstanding - 1)) ? '0 : aq_wr_q + 1'b1;
      end
      if (push) begin
        aq_rd_q <= (aq_rd_q == QW'(MaxOutstanding - 1)) ? '0 : aq_rd_q + 1'b1;
      end
    end
  end

  // Storage writes: response data with its request address, and addresses
  // of accepted live requests.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr[wr_q] <= bus.instr_rdata_i;
      fifo_addr[wr_q]  <= addr_queue[aq_rd_q];
    end
    if (fresh_acc) begin
      addr_queue[aq_wr_q] <= req_addr;
    end
  end

  a_no_orphan_resp: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(bus.instr_valid_i && (out_q == '0)));

endmodule
